// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - architectural PC owner and fetch/execute/commit sequencer
`timescale 1ns/1ps

module pc_sequencer #(
    parameter int               XLEN     = 64,
    parameter logic [XLEN-1:0]  RESET_PC = 64'h8000_0000
) (
    input  logic             clk,
    input  logic             rst,

    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    output logic [XLEN-1:0]  ifu_req_addr,
    input  logic             ifu_resp_valid,
    input  logic [31:0]      ifu_resp_inst,
    input  logic             ifu_resp_err,

    output logic             inst_valid,
    output logic [31:0]      inst,
    output logic [XLEN-1:0]  pc,

    input  logic             exu_done,
    input  logic [XLEN-1:0]  next_pc,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             halt_req,

    output logic             fetch_fault,
    output logic             halted,
    output logic [XLEN-1:0]  retire_cnt
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        EXEC = 2'd2,
        STOP = 2'd3
    } state_t;

    // Committed targets drop bit 0; bit 1 survives so REQ can flag misalignment.
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [XLEN-1:0] ONE        = {{(XLEN-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic              fault_q, fault_d;
    logic              halted_q, halted_d;
    logic [XLEN-1:0]   retire_q, retire_d;

    logic              pc_aligned;

    assign pc_aligned = (pc_q[1:0] == 2'b00);

    // Request is decoded from state; suppressed while reset is being applied.
    assign ifu_req_valid = (state_q == REQ) && pc_aligned && !rst;
    assign ifu_req_addr  = pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        fault_d      = fault_q;
        halted_d     = halted_q;
        retire_d     = retire_q;

        unique case (state_q)
            REQ: begin
                inst_valid_d = 1'b0;
                if (!pc_aligned) begin
                    fault_d = 1'b1;
                    state_d = STOP;
                end else if (ifu_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ifu_resp_valid) begin
                    if (ifu_resp_err) begin
                        fault_d = 1'b1;
                        state_d = STOP;
                    end else begin
                        inst_d       = ifu_resp_inst;
                        inst_valid_d = 1'b1;
                        state_d      = EXEC;
                    end
                end
            end
            EXEC: begin
                if (exu_done) begin
                    inst_valid_d = 1'b0;
                    retire_d     = retire_q + ONE;
                    if (halt_req) begin
                        halted_d = 1'b1;
                        state_d  = STOP;
                    end else if (redirect_valid) begin
                        pc_d    = redirect_pc & ALIGN_MASK;
                        state_d = REQ;
                    end else begin
                        pc_d    = next_pc & ALIGN_MASK;
                        state_d = REQ;
                    end
                end
            end
            STOP: begin
                inst_valid_d = 1'b0;
            end
            default: begin
                state_d = STOP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0;
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            halted_q     <= 1'b0;
            retire_q     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            fault_q      <= fault_d;
            halted_q     <= halted_d;
            retire_q     <= retire_d;
        end
    end

    assign pc          = pc_q;
    assign inst        = inst_q;
    assign inst_valid  = inst_valid_q;
    assign fetch_fault = fault_q;
    assign halted      = halted_q;
    assign retire_cnt  = retire_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer fetch/commit sequencing
`timescale 1ns/1ps

module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid;
    logic        ifu_req_ready = 1'b0;
    logic [63:0] ifu_req_addr;
    logic        ifu_resp_valid = 1'b0;
    logic [31:0] ifu_resp_inst = 32'h0;
    logic        ifu_resp_err = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        exu_done = 1'b0;
    logic [63:0] next_pc = 64'h0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        halt_req = 1'b0;
    logic        fetch_fault;
    logic        halted;
    logic [63:0] retire_cnt;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_hs = 0;
    int          prev_hs = 0;
    logic [63:0] exp_q[$];

    pc_sequencer #(.XLEN(64), .RESET_PC(64'h8000_0000)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr), .ifu_resp_valid(ifu_resp_valid),
        .ifu_resp_inst(ifu_resp_inst), .ifu_resp_err(ifu_resp_err),
        .inst_valid(inst_valid), .inst(inst), .pc(pc),
        .exu_done(exu_done), .next_pc(next_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .fetch_fault(fetch_fault), .halted(halted),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted fetch request must match the next expected address.
    always @(negedge clk) begin
        if (!rst && ifu_req_valid && ifu_req_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_fetch: got addr 0x%0h expected no request", ifu_req_addr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (ifu_req_addr !== e) begin
                    n_fail++;
                    $display("FAIL fetch_addr: got 0x%0h expected 0x%0h", ifu_req_addr, e);
                end
            end
            prev_hs = last_hs;
            last_hs = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifu_req_ready = 1'b0;
        ifu_resp_valid = 1'b0;
        exu_done = 1'b0;
        step();
        chk("req_valid_in_reset", {63'b0, ifu_req_valid}, 64'd0);
        rst = 1'b0;
        chk("rst_pc", pc, 64'h8000_0000);
        chk("rst_inst_valid", {63'b0, inst_valid}, 64'd0);
        chk("rst_fault", {63'b0, fetch_fault}, 64'd0);
        chk("rst_halted", {63'b0, halted}, 64'd0);
        chk("rst_retire", retire_cnt, 64'd0);
    endtask

    task automatic fetch(input logic [63:0] a, input int stall);
        int n;
        exp_q.push_back(a);
        n = 0;
        while (!ifu_req_valid && n < 10) begin
            step();
            n++;
        end
        chk("req_seen", {63'b0, ifu_req_valid}, 64'd1);
        for (int i = 0; i < stall; i++) begin
            chk("stall_valid", {63'b0, ifu_req_valid}, 64'd1);
            chk("stall_addr", ifu_req_addr, a);
            step();
        end
        ifu_req_ready = 1'b1;
        step();
        ifu_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] w, input logic err);
        ifu_resp_valid = 1'b1;
        ifu_resp_inst = w;
        ifu_resp_err = err;
        step();
        ifu_resp_valid = 1'b0;
        ifu_resp_err = 1'b0;
    endtask

    task automatic execute(input logic [63:0] npc, input logic rv, input logic [63:0] rpc, input logic h);
        exu_done = 1'b1;
        next_pc = npc;
        redirect_valid = rv;
        redirect_pc = rpc;
        halt_req = h;
        step();
        exu_done = 1'b0;
        redirect_valid = 1'b0;
        halt_req = 1'b0;
    endtask

    task automatic expect_idle(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            chk(name, {63'b0, ifu_req_valid}, 64'd0);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        do_reset();

        // Basic loop with a stalled first handshake
        fetch(64'h8000_0000, 4);
        respond(32'h0000_0013, 1'b0);
        chk("inst_valid_exec", {63'b0, inst_valid}, 64'd1);
        chk("inst_latched", {32'b0, inst}, 64'h13);
        execute(64'h8000_0004, 1'b0, 64'h0, 1'b0);
        chk("inst_valid_after_done", {63'b0, inst_valid}, 64'd0);
        chk("retire_1", retire_cnt, 64'd1);
        chk("pc_seq", pc, 64'h8000_0004);
        fetch(64'h8000_0004, 0);
        respond(32'h0000_0013, 1'b0);
        execute(64'h8000_0008, 1'b0, 64'h0, 1'b0);
        fetch(64'h8000_0008, 0);
        chk("loop_cycles", 64'(last_hs - prev_hs), 64'd3);

        // Redirect priority and bit-0 clearing
        respond(32'h3020_0073, 1'b0);
        execute(64'h8000_0008, 1'b1, 64'h8000_0100, 1'b0);
        chk("pc_redirect", pc, 64'h8000_0100);
        fetch(64'h8000_0100, 0);
        respond(32'h0000_0013, 1'b0);
        execute(64'h8000_0011, 1'b0, 64'h0, 1'b0);
        chk("pc_bit0_clear", pc, 64'h8000_0010);
        fetch(64'h8000_0010, 0);
        respond(32'h0000_0013, 1'b0);
        execute(64'h8000_0006, 1'b0, 64'h0, 1'b0);
        chk("retire_5", retire_cnt, 64'd5);
        chk("pc_misaligned", pc, 64'h8000_0006);
        expect_idle("misaligned_no_req", 4);
        chk("misaligned_fault", {63'b0, fetch_fault}, 64'd1);
        chk("misaligned_not_halted", {63'b0, halted}, 64'd0);

        // Fetch access error
        do_reset();
        fetch(64'h8000_0000, 0);
        respond(32'hdead_beef, 1'b1);
        chk("err_fault", {63'b0, fetch_fault}, 64'd1);
        chk("err_inst_valid", {63'b0, inst_valid}, 64'd0);
        chk("err_inst_unchanged", {32'b0, inst}, 64'd0);
        expect_idle("err_no_req", 4);
        chk("err_inst_valid_later", {63'b0, inst_valid}, 64'd0);

        // Halt wins over redirect
        do_reset();
        fetch(64'h8000_0000, 0);
        respond(32'h0010_0073, 1'b0);
        execute(64'h8000_0004, 1'b1, 64'h8000_0200, 1'b1);
        chk("halt_flag", {63'b0, halted}, 64'd1);
        chk("halt_pc", pc, 64'h8000_0000);
        chk("halt_retire", retire_cnt, 64'd1);
        chk("halt_inst_valid", {63'b0, inst_valid}, 64'd0);
        ifu_req_ready = 1'b1;
        expect_idle("halt_no_req", 5);
        ifu_req_ready = 1'b0;

        // Reset in EXEC
        do_reset();
        fetch(64'h8000_0000, 0);
        respond(32'h0000_0013, 1'b0);
        execute(64'h8000_0004, 1'b0, 64'h0, 1'b0);
        fetch(64'h8000_0004, 0);
        respond(32'h0000_0013, 1'b0);
        chk("pre_rst_inst_valid", {63'b0, inst_valid}, 64'd1);
        do_reset();

        // Reset in WAIT
        fetch(64'h8000_0000, 0);
        do_reset();

        // Stray pulses in REQ are ignored
        ifu_resp_valid = 1'b1;
        ifu_resp_inst = 32'hdead_beef;
        exu_done = 1'b1;
        next_pc = 64'h8000_0040;
        step();
        ifu_resp_valid = 1'b0;
        exu_done = 1'b0;
        chk("stray_inst_valid", {63'b0, inst_valid}, 64'd0);
        chk("stray_inst", {32'b0, inst}, 64'd0);
        chk("stray_retire", retire_cnt, 64'd0);
        chk("stray_pc", pc, 64'h8000_0000);
        fetch(64'h8000_0000, 0);
        respond(32'h0000_0013, 1'b0);
        chk("post_stray_inst", {32'b0, inst}, 64'h13);
        step();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the architectural PC and sequences the single-issue NPC core through fetch, execute and commit. It issues instruction-fetch requests over a valid/ready channel, holds the fetched instruction stable for the execute stage, and commits the next-PC value computed by the next-PC datapath. Trap/return redirects, fetch faults and halt (ebreak) are handled here. It sits between the instruction memory interface and the decode/execute datapath.

Parameters:
RESET_PC, 64'h8000_0000, PC value loaded on reset
XLEN, 64, PC and address width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
ifu_req_valid  output  1  fetch request valid
ifu_req_ready  input  1  memory accepts request
ifu_req_addr  output  XLEN  fetch address, equals pc
ifu_resp_valid  input  1  fetch response valid, one-cycle pulse
ifu_resp_inst  input  32  fetched instruction word
ifu_resp_err  input  1  fetch access error, qualified by ifu_resp_valid
inst_valid  output  1  inst/pc valid for execute stage
inst  output  32  registered instruction
pc  output  XLEN  current architectural PC
exu_done  input  1  execute complete; next_pc and redirect sampled this cycle
next_pc  input  XLEN  sequential/branch target from next-PC datapath
redirect_valid  input  1  trap/mret redirect, qualified by exu_done
redirect_pc  input  XLEN  redirect target
halt_req  input  1  ebreak retiring, qualified by exu_done
fetch_fault  output  1  sticky: fetch error or misaligned PC
halted  output  1  sticky: core stopped
retire_cnt  output  XLEN  committed instruction count

Behaviour:
- States: REQ, WAIT, EXEC, STOP. Reset -> REQ, pc=RESET_PC, inst=0, inst_valid=0, ifu_req_valid=0 in the reset cycle, fetch_fault=0, halted=0, retire_cnt=0.
- REQ: ifu_req_valid=1, ifu_req_addr=pc. Before asserting, if pc[1:0]!=0 -> set fetch_fault, go STOP without request. Valid stays high and addr stable until ifu_req_ready; handshake cycle -> WAIT.
- WAIT: ifu_req_valid=0. On ifu_resp_valid: err=1 -> fetch_fault=1, STOP, inst unchanged; err=0 -> latch inst, inst_valid=1, EXEC.
- EXEC: inst and pc held stable; inst_valid=1. On exu_done: inst_valid=0 next cycle, retire_cnt+1 (wraps modulo 2^XLEN).
  Priority: halt_req -> halted=1, pc unchanged, STOP; else redirect_valid -> pc=redirect_pc; else pc=next_pc. Then REQ.
  Bit 0 of committed target is forced to 0; bit 1 left as-is (misalignment caught in REQ).
- Minimum loop: REQ(1) + WAIT(>=1) + EXEC(>=1) = 3 cycles per instruction with zero-wait memory.
- STOP: all requests deasserted, inst_valid=0; absorbing until rst. halted/fetch_fault hold.
- ifu_resp_valid outside WAIT: ignored. exu_done outside EXEC: ignored; no retire.
- rst mid-transaction (any state): next cycle state exactly as reset; in-flight response after reset is ignored unless in WAIT (memory is reset with core).
- All outputs registered except ifu_req_valid/ifu_req_addr, decoded from state/pc.

Test Plan:
- Reset, ready=1, 1-cycle response inst 0x00000013, exu_done with next_pc=0x8000_0004 -> req addr 0x8000_0000, then 0x8000_0004; retire_cnt=1; 3 cycles between requests.
- ifu_req_ready low 4 cycles -> ifu_req_valid held, addr stable 0x8000_0000, one handshake only.
- exu_done with redirect_valid=1 redirect_pc=0x8000_0100, next_pc=0x8000_0008 -> next fetch 0x8000_0100; next_pc=0x8000_0011 (no redirect) -> fetch 0x8000_0010.
- next_pc=0x8000_0006 -> fetch_fault=1, no request issued, STOP; ifu_resp_err=1 in WAIT -> fetch_fault=1, inst_valid never set.
- halt_req with exu_done and redirect_valid both high -> halted=1, pc unchanged, retire_cnt incremented, no further requests.
- rst asserted in EXEC and in WAIT -> next cycle pc=0x8000_0000, inst_valid=0, flags and retire_cnt cleared; stray resp_valid/exu_done pulses in REQ ignored.
